cu_pipe: RTL

CU_PIPE -- requirements
Module: cu_pipe

---
 rtl/riscv_structures_pkg.sv | 90 +++++++++
 rtl/cu_decode.sv | 114 +++++++++++
 rtl/cu_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/riscv_structures_pkg.sv
// Shared RISC-V decode types: ALU ops, instruction formats, control bundle and opcodes.
// Encodings of ALU_INVALID / INVALID_TYPE are zero so a cleared bundle means "no op".
package riscv_structures;

    typedef enum logic [4:0] {
        ALU_INVALID = 5'd0,
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [2:0] {
        INVALID_TYPE = 3'd0, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } instr_type_e;

    typedef enum logic [1:0] {EMPTY, FULL, MULDIV} pipe_state_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        use_imm;
        logic        is_branch;
        logic        is_jump;
        logic        is_jalr;
        instr_type_e instr_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
    } ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic alu_op_e base_alu(input logic [2:0] f3);
        alu_op_e op;
        op = ALU_INVALID;
        case (f3)
            3'b000: op = ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_INVALID;
        endcase
        return op;
    endfunction

    function automatic alu_op_e muldiv_alu(input logic [2:0] f3);
        alu_op_e op;
        op = ALU_INVALID;
        case (f3)
            3'b000: op = ALU_MUL;
            3'b001: op = ALU_MULH;
            3'b010: op = ALU_MULHSU;
            3'b011: op = ALU_MULHU;
            3'b100: op = ALU_DIV;
            3'b101: op = ALU_DIVU;
            3'b110: op = ALU_REM;
            3'b111: op = ALU_REMU;
            default: op = ALU_INVALID;
        endcase
        return op;
    endfunction

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c = '0;
        c.alu_op     = ALU_INVALID;
        c.instr_type = INVALID_TYPE;
        return c;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I(+M) decoder producing the control bundle for one instruction word.
module cu_decode
    import riscv_structures::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        is_muldiv
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    alu_op_e     alu;
    instr_type_e ty;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        alu       = ALU_INVALID;
        ty        = INVALID_TYPE;
        is_muldiv = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    alu = base_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu = ALU_SRA;
                end else if (funct7 == F7_MULDIV && ENABLE_M) begin
                    alu       = muldiv_alu(funct3);
                    is_muldiv = 1'b1;
                end
                if (alu != ALU_INVALID) ty = R_TYPE;
            end
            OPC_OP_IMM: begin
                // shift-immediates reuse funct7 as a qualifier; everything else ignores it
                case (funct3)
                    3'b001:  alu = (funct7 == F7_BASE) ? ALU_SLL : ALU_INVALID;
                    3'b101:  alu = (funct7 == F7_BASE) ? ALU_SRL :
                                   (funct7 == F7_ALT)  ? ALU_SRA : ALU_INVALID;
                    default: alu = base_alu(funct3);
                endcase
                if (alu != ALU_INVALID) ty = I_TYPE;
            end
            OPC_LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    alu = ALU_ADD;
                    ty  = I_TYPE;
                end
            end
            OPC_STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    alu = ALU_ADD;
                    ty  = S_TYPE;
                end
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    alu = ALU_ADD;
                    ty  = B_TYPE;
                end
            end
            OPC_JAL: begin
                alu = ALU_ADD;
                ty  = J_TYPE;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    alu = ALU_ADD;
                    ty  = I_TYPE;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                alu = ALU_ADD;
                ty  = U_TYPE;
            end
            OPC_SYSTEM: begin
                if (funct3 != 3'b100) begin
                    alu = ALU_ADD;
                    ty  = I_TYPE;
                end
            end
            default: begin
                alu = ALU_INVALID;
                ty  = INVALID_TYPE;
            end
        endcase

        ctrl        = '0;
        ctrl.rd     = instr[11:7];
        ctrl.rs1    = instr[19:15];
        ctrl.rs2    = instr[24:20];
        ctrl.funct3 = funct3;
        illegal     = (ty == INVALID_TYPE);
        if (!illegal) begin
            ctrl.alu_op     = alu;
            ctrl.instr_type = ty;
            ctrl.use_imm    = (ty inside {I_TYPE, S_TYPE, U_TYPE, J_TYPE});
            ctrl.reg_write  = (ty != S_TYPE) && (ty != B_TYPE) && (instr[11:7] != 5'd0);
            ctrl.mem_read   = (opcode == OPC_LOAD);
            ctrl.mem_write  = (opcode == OPC_STORE);
            ctrl.is_branch  = (opcode == OPC_BRANCH);
            ctrl.is_jump    = (opcode == OPC_JAL) || (opcode == OPC_JALR);
            ctrl.is_jalr    = (opcode == OPC_JALR);
        end
    end

endmodule

// File: rtl/cu_pipe.sv
// Single decode pipeline stage with valid/ready handshake and multi-cycle RV32M occupancy.
// state  | meaning
// EMPTY  | nothing held, accepting
// MULDIV | M op held, counting down before it may leave
// FULL   | out_ctrl valid, waiting for out_ready
module cu_pipe
    import riscv_structures::*;
#(
    parameter int ENABLE_M      = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output ctrl_t       out_ctrl,
    output logic        illegal
);

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam bit MULTI = (MULDIV_CYCLES > 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);

    pipe_state_e   state;
    logic [CW-1:0] cnt;
    ctrl_t         dec_ctrl;
    logic          dec_illegal;
    logic          dec_muldiv;
    logic          accept;

    cu_decode #(.ENABLE_M(ENABLE_M != 0)) u_decode (
        .instr     (instr),
        .ctrl      (dec_ctrl),
        .illegal   (dec_illegal),
        .is_muldiv (dec_muldiv)
    );

    always_comb begin
        in_ready = !flush && ((state == EMPTY) || (state == FULL && out_ready));
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            cnt       <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            out_ctrl  <= ctrl_reset();
        end else if (flush) begin
            state     <= EMPTY;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            // covers both a fresh load from EMPTY and retire-with-refill from FULL
            out_ctrl <= dec_ctrl;
            illegal  <= dec_illegal;
            if (dec_muldiv && MULTI) begin
                state     <= MULDIV;
                cnt       <= CNT_LOAD;
                out_valid <= 1'b0;
            end else begin
                state     <= FULL;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                MULDIV: begin
                    if (cnt == CW'(1)) begin
                        state     <= FULL;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
